// File: rtl/e203_longp_pkg.sv
// Shared defaults and the buffered-result record used by the long-pipe
// write-back buffer and its per-entry storage.
package e203_longp_pkg;

  localparam int ITAG_W_DEF = 1;

  typedef struct packed {
    logic [31:0] wdat;
    logic        err;
    logic [31:0] badaddr;
  } longp_entry_t;

endpackage

// File: rtl/e203_longp_buf_entry.sv
// One write-back buffer slot: a valid flag with async clear plus an
// unreset payload that is only meaningful while the flag is set.
module e203_longp_buf_entry
  import e203_longp_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         set_i,
  input  logic         clr_i,
  input  longp_entry_t set_data_i,
  output logic         vld_o,
  output longp_entry_t data_o
);

  logic         vld_q, vld_d;
  longp_entry_t data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (set_i) begin
      vld_d  = 1'b1;
      data_d = set_data_i;
    end else if (clr_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Payload is always qualified by vld_q, so it carries no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/e203_exu_longp_wbck_buf.sv
// Long-pipe write-back buffer: parks LSU/NICE completions by OITF tag and
// releases them to write-back or exception strictly in OITF order.
module e203_exu_longp_wbck_buf
  import e203_longp_pkg::*;
#(
  parameter int ITAG_W = ITAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              lsu_i_valid,
  output logic              lsu_i_ready,
  input  logic [ITAG_W-1:0] lsu_i_itag,
  input  logic [31:0]       lsu_i_wdat,
  input  logic              lsu_i_err,
  input  logic [31:0]       lsu_i_badaddr,

  input  logic              nice_i_valid,
  output logic              nice_i_ready,
  input  logic [ITAG_W-1:0] nice_i_itag,
  input  logic [31:0]       nice_i_wdat,
  input  logic              nice_i_err,

  input  logic              oitf_empty,
  input  logic [ITAG_W-1:0] oitf_ret_ptr,
  input  logic [4:0]        oitf_ret_rdidx,
  input  logic              oitf_ret_rdwen,
  input  logic              oitf_ret_rdfpu,
  input  logic [31:0]       oitf_ret_pc,
  output logic              oitf_ret_ena,

  output logic              wbck_o_valid,
  input  logic              wbck_o_ready,
  output logic [31:0]       wbck_o_wdat,
  output logic [4:0]        wbck_o_rdidx,
  output logic              wbck_o_rdfpu,

  output logic              excp_o_valid,
  input  logic              excp_o_ready,
  output logic [31:0]       excp_o_pc,
  output logic [31:0]       excp_o_badaddr
);

  localparam int DEPTH = 1 << ITAG_W;

  logic [DEPTH-1:0] vld;
  longp_entry_t     ent [DEPTH];
  longp_entry_t     lsu_ent, nice_ent, head;
  logic             lsu_hsk, nice_hsk, head_act;

  // LSU wins a same-tag collision, so NICE is held off whenever LSU targets its slot.
  always_comb begin
    lsu_i_ready  = !vld[lsu_i_itag];
    nice_i_ready = !vld[nice_i_itag] && !(lsu_i_valid && (lsu_i_itag == nice_i_itag));
    lsu_hsk      = lsu_i_valid && lsu_i_ready;
    nice_hsk     = nice_i_valid && nice_i_ready;
    lsu_ent      = '{wdat: lsu_i_wdat, err: lsu_i_err, badaddr: lsu_i_badaddr};
    nice_ent     = '{wdat: nice_i_wdat, err: nice_i_err, badaddr: 32'h0};
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_ent
    logic lsu_sel, nice_sel;
    assign lsu_sel  = lsu_hsk && (lsu_i_itag == ITAG_W'(k));
    assign nice_sel = nice_hsk && (nice_i_itag == ITAG_W'(k));

    e203_longp_buf_entry u_entry (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_i      (lsu_sel || nice_sel),
      .clr_i      (oitf_ret_ena && (oitf_ret_ptr == ITAG_W'(k))),
      .set_data_i (lsu_sel ? lsu_ent : nice_ent),
      .vld_o      (vld[k]),
      .data_o     (ent[k])
    );
  end

  // Only the OITF head may drain; an erroring head goes to commit instead of the register file.
  always_comb begin
    head           = ent[oitf_ret_ptr];
    head_act       = !oitf_empty && vld[oitf_ret_ptr];
    wbck_o_valid   = head_act && !head.err && oitf_ret_rdwen;
    excp_o_valid   = head_act && head.err;
    oitf_ret_ena   = head_act && (head.err ? excp_o_ready : (!oitf_ret_rdwen || wbck_o_ready));
    wbck_o_wdat    = head.wdat;
    wbck_o_rdidx   = oitf_ret_rdidx;
    wbck_o_rdfpu   = oitf_ret_rdfpu;
    excp_o_pc      = oitf_ret_pc;
    excp_o_badaddr = head.badaddr;
  end

endmodule

// File: doc/e203_exu_longp_wbck_buf.md
E203_EXU_LONGP_WBCK_BUF -- requirements
Module: e203_exu_longp_wbck_buf

Interface
REQ-001 SHALL have parameter ITAG_W, default 1, meaning the OITF pointer width; buffer depth is 2^ITAG_W.
REQ-002 SHALL have ports clk  in  1  clock, rising-edge; rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports lsu_i_valid  in  1; lsu_i_ready  out  1; lsu_i_itag  in  ITAG_W; lsu_i_wdat  in  32; lsu_i_err  in  1; lsu_i_badaddr  in  32: LSU completion channel.
REQ-004 SHALL have ports nice_i_valid  in  1; nice_i_ready  out  1; nice_i_itag  in  ITAG_W; nice_i_wdat  in  32; nice_i_err  in  1: coprocessor completion channel.
REQ-005 SHALL have ports oitf_empty  in  1; oitf_ret_ptr  in  ITAG_W; oitf_ret_rdidx  in  5; oitf_ret_rdwen  in  1; oitf_ret_rdfpu  in  1; oitf_ret_pc  in  32: OITF head entry.
REQ-006 SHALL have port oitf_ret_ena  out  1: pops the OITF head.
REQ-007 SHALL have ports wbck_o_valid  out  1; wbck_o_ready  in  1; wbck_o_wdat  out  32; wbck_o_rdidx  out  5; wbck_o_rdfpu  out  1: register-file write-back.
REQ-008 SHALL have ports excp_o_valid  out  1; excp_o_ready  in  1; excp_o_pc  out  32; excp_o_badaddr  out  32: exception to commit.

Function
REQ-009 SHALL hold per entry k: vld, wdat[31:0], err, badaddr[31:0].
REQ-010 SHALL drive lsu_i_ready = !vld[lsu_i_itag]; on lsu_i_valid&&lsu_i_ready SHALL capture wdat/err/badaddr into entry lsu_i_itag and set its vld.
REQ-011 SHALL drive nice_i_ready = !vld[nice_i_itag] && !(lsu_i_valid && lsu_i_itag==nice_i_itag); on handshake SHALL capture with badaddr=0.
REQ-012 SHALL register completions only; an entry written in cycle N SHALL drive outputs no earlier than cycle N+1 (no bypass).
REQ-013 SHALL define head = entry oitf_ret_ptr and head_act = !oitf_empty && vld[head].
REQ-014 head_act && !err && rdwen: wbck_o_valid=1, wdat/rdidx/rdfpu from head and OITF; retire only on wbck_o_ready.
REQ-015 head_act && !err && !rdwen: SHALL retire in the same cycle with no write-back or exception.
REQ-016 head_act && err: excp_o_valid=1, excp_o_pc=oitf_ret_pc, excp_o_badaddr=head badaddr; retire only on excp_o_ready; wbck_o_valid SHALL stay 0.
REQ-017 Retire SHALL mean oitf_ret_ena=1 for one cycle and clear vld[head] at the clock edge.
REQ-018 Non-head entries SHALL wait regardless of arrival order; retirement SHALL follow OITF order.
REQ-019 A capture into entry j and retire of head k!=j in the same cycle SHALL both take effect.
REQ-020 oitf_empty=1 SHALL force wbck_o_valid, excp_o_valid and oitf_ret_ena to 0.
REQ-021 wbck_o_valid and excp_o_valid SHALL never both be 1.

Reset
REQ-022 rst_n low SHALL clear all vld immediately, without waiting for clk; wbck_o_valid, excp_o_valid, oitf_ret_ena SHALL be 0 while low.
REQ-023 wdat/err/badaddr SHALL not require reset; outputs derived from them are don't-care while the valid outputs are 0.
REQ-024 Reset mid-handshake SHALL discard all buffered results.

Structure
REQ-025 Shared package e203_longp_pkg SHALL hold ITAG_W default and the entry record type.
REQ-026 One sub-module e203_longp_buf_entry (single entry storage, set/clear) SHALL be instantiated 2^ITAG_W times.

Verification
REQ-027 Reset: after lsu fills entry 0, rst_n pulsed low mid-cycle -> vld cleared at once, lsu_i_ready=1, all valid outputs 0.
REQ-028 In-order: OITF ptr=0 rdidx=1 rdwen=1; LSU itag=1 wdat=0xBBBB then itag=0 wdat=0xAAAA -> wbck 0xAAAA rd1 first, then ptr=1 wbck 0xBBBB.
REQ-029 Backpressure: head valid, wbck_o_ready=0 for 3 cycles -> wbck_o_valid held, data stable, oitf_ret_ena=0 until ready=1, then a one-cycle pulse.
REQ-030 Error: LSU itag=0 err=1 badaddr=0x8000_0004, ret_pc=0x100 -> excp_o_valid, pc=0x100, badaddr=0x8000_0004, no write-back.
REQ-031 Collision: LSU and NICE both valid itag=1 -> lsu_i_ready=1, nice_i_ready=0, LSU data retired.
REQ-032 No-write: head rdwen=0 err=0 -> oitf_ret_ena=1 the cycle after capture, wbck_o_valid stays 0.
